// File: rtl/osd_mam_arbiter.sv
// Transaction-level arbiter sharing one MAM access port between NUM_REQ requesters.
// Define OSD_MAM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module osd_mam_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              s_req_valid,
    output logic [NUM_REQ-1:0]              s_req_ready,
    input  logic [NUM_REQ-1:0]              s_req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [NUM_REQ-1:0]              s_req_burst,
    input  logic [NUM_REQ*13-1:0]           s_req_beats,
    input  logic [NUM_REQ-1:0]              s_write_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_write_data,
    input  logic [NUM_REQ*DATA_WIDTH/8-1:0] s_write_strb,
    output logic [NUM_REQ-1:0]              s_write_ready,
    output logic [NUM_REQ-1:0]              s_read_valid,
    output logic [DATA_WIDTH-1:0]           s_read_data,
    input  logic [NUM_REQ-1:0]              s_read_ready,
    output logic                            m_req_valid,
    input  logic                            m_req_ready,
    output logic                            m_req_we,
    output logic [ADDR_WIDTH-1:0]           m_req_addr,
    output logic                            m_req_burst,
    output logic [12:0]                     m_req_beats,
    output logic                            m_write_valid,
    output logic [DATA_WIDTH-1:0]           m_write_data,
    output logic [DATA_WIDTH/8-1:0]         m_write_strb,
    input  logic                            m_write_ready,
    input  logic                            m_read_valid,
    input  logic [DATA_WIDTH-1:0]           m_read_data,
    output logic                            m_read_ready,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            busy
);

    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned SW = DATA_WIDTH / 8;
    localparam logic [GW:0] NumReqW = (GW+1)'(NUM_REQ);
    localparam logic [GW-1:0] LastIdx = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {StIdle, StReq, StData} state_e;

    state_e          state_q;
    logic [GW-1:0]   grant_q;
    logic [GW-1:0]   rr_q;
    logic [12:0]     cnt_q;
    logic            we_q;
    logic            busy_q;

    logic [ADDR_WIDTH-1:0] req_addr  [NUM_REQ];
    logic [12:0]           req_beats [NUM_REQ];
    logic [DATA_WIDTH-1:0] wr_data   [NUM_REQ];
    logic [SW-1:0]         wr_strb   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_addr[i]  = s_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign req_beats[i] = s_req_beats[i*13 +: 13];
        assign wr_data[i]   = s_write_data[i*DATA_WIDTH +: DATA_WIDTH];
        assign wr_strb[i]   = s_write_strb[i*SW +: SW];
    end

    // Search starts at rr_q; with fixed priority rr_q never leaves 0.
    logic          win_found;
    logic [GW-1:0] win_idx;
    logic [GW:0]   idx_w;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        idx_w     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx_w = {1'b0, rr_q} + (GW+1)'(k);
            if (idx_w >= NumReqW) idx_w = idx_w - NumReqW;
            if (!win_found && s_req_valid[idx_w[GW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = idx_w[GW-1:0];
            end
        end
    end

    // Zero-latency mux toward the downstream port; non-owners see only zeros.
    always_comb begin
        m_req_valid   = 1'b0;
        s_req_ready   = '0;
        m_write_valid = 1'b0;
        s_write_ready = '0;
        s_read_valid  = '0;
        m_read_ready  = 1'b0;
        m_req_we      = s_req_we[grant_q];
        m_req_addr    = req_addr[grant_q];
        m_req_burst   = s_req_burst[grant_q];
        m_req_beats   = req_beats[grant_q];
        m_write_data  = wr_data[grant_q];
        m_write_strb  = wr_strb[grant_q];
        unique case (state_q)
            StReq: begin
                m_req_valid          = s_req_valid[grant_q];
                s_req_ready[grant_q] = m_req_ready;
            end
            StData: begin
                if (we_q) begin
                    m_write_valid          = s_write_valid[grant_q];
                    s_write_ready[grant_q] = m_write_ready;
                end else begin
                    s_read_valid[grant_q] = m_read_valid;
                    m_read_ready          = s_read_ready[grant_q];
                end
            end
            default: ;
        endcase
    end

    assign s_read_data = m_read_data;
    assign grant_id    = grant_q;
    assign busy        = busy_q;

    logic hs_data;
    assign hs_data = we_q ? (m_write_valid & m_write_ready) : (m_read_valid & m_read_ready);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q <= win_idx;
                        busy_q  <= 1'b1;
                        state_q <= StReq;
                    end
                end
                StReq: begin
                    if (m_req_valid && m_req_ready) begin
                        // A zero-length burst still moves one word.
                        cnt_q   <= (s_req_burst[grant_q] && req_beats[grant_q] != 13'd0)
                                   ? req_beats[grant_q] : 13'd1;
                        we_q    <= s_req_we[grant_q];
                        state_q <= StData;
                    end
                end
                StData: begin
                    if (hs_data) begin
                        if (cnt_q == 13'd1) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
`ifndef OSD_MAM_ARB_FIXED_PRIO_EN
                            rr_q    <= (grant_q == LastIdx) ? '0 : grant_q + 1'b1;
`endif
                        end else begin
                            cnt_q <= cnt_q - 13'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_osd_mam_arbiter.sv
// Directed self-checking bench for osd_mam_arbiter (NUM_REQ=2, DATA_WIDTH=16, ADDR_WIDTH=32).
module tb_osd_mam_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  s_req_valid = '0, s_req_ready, s_req_we = '0, s_req_burst = '0;
    logic [63:0] s_req_addr = '0;
    logic [25:0] s_req_beats = '0;
    logic [1:0]  s_write_valid = '0, s_write_ready, s_read_valid, s_read_ready = '0;
    logic [31:0] s_write_data = '0;
    logic [3:0]  s_write_strb = '1;
    logic [15:0] s_read_data;
    logic        m_req_valid, m_req_ready = 1'b0, m_req_we, m_req_burst;
    logic [31:0] m_req_addr;
    logic [12:0] m_req_beats;
    logic        m_write_valid, m_write_ready = 1'b0;
    logic [15:0] m_write_data;
    logic [1:0]  m_write_strb;
    logic        m_read_valid = 1'b0, m_read_ready;
    logic [15:0] m_read_data = 16'h0;
    logic [0:0]  grant_id;
    logic        busy;

    int tests = 0;
    int fails = 0;

    osd_mam_arbiter #(.NUM_REQ(2), .DATA_WIDTH(16), .ADDR_WIDTH(32)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_we(s_req_we),
        .s_req_addr(s_req_addr), .s_req_burst(s_req_burst), .s_req_beats(s_req_beats),
        .s_write_valid(s_write_valid), .s_write_data(s_write_data),
        .s_write_strb(s_write_strb), .s_write_ready(s_write_ready),
        .s_read_valid(s_read_valid), .s_read_data(s_read_data), .s_read_ready(s_read_ready),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
        .m_req_addr(m_req_addr), .m_req_burst(m_req_burst), .m_req_beats(m_req_beats),
        .m_write_valid(m_write_valid), .m_write_data(m_write_data),
        .m_write_strb(m_write_strb), .m_write_ready(m_write_ready),
        .m_read_valid(m_read_valid), .m_read_data(m_read_data), .m_read_ready(m_read_ready),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Runs one granted transaction for requester g and counts data handshakes.
    task automatic serve(input logic g, input int beats, input logic wr, input logic [1:0] drop,
                         input logic [1:0] raise, input logic stall, input logic [31:0] addr);
        int n;
        logic hs;
        logic [1:0] own;
        own = (g == 1'b1) ? 2'b10 : 2'b01;
        for (int i = 0; i < 10 && !busy; i++) cyc();
        chk("busy_set", {31'd0, busy}, 32'd1);
        chk("grant_id", {31'd0, grant_id}, {31'd0, g});
        chk("m_req_valid", {31'd0, m_req_valid}, 32'd1);
        chk("m_req_addr", m_req_addr, addr);
        s_req_valid = s_req_valid | raise;
        m_req_ready = 1'b1;
        #1;
        chk("s_req_ready", {30'd0, s_req_ready}, {30'd0, own});
        cyc();
        m_req_ready = 1'b0;
        s_req_valid = s_req_valid & ~drop;
        if (wr) s_write_valid = s_write_valid | own;
        else begin
            m_read_valid = 1'b1;
            s_read_ready = own;
        end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            m_write_ready = !(stall && i >= 1 && i <= 5);
            #1;
            hs = wr ? (m_write_valid & m_write_ready) : (m_read_valid & m_read_ready);
            if (wr) begin
                chk("s_write_ready", {30'd0, s_write_ready}, m_write_ready ? {30'd0, own} : 32'd0);
                if (hs) chk("m_write_data", {16'd0, m_write_data},
                            {16'd0, (g == 1'b1) ? s_write_data[31:16] : s_write_data[15:0]});
            end else begin
                chk("s_read_valid", {30'd0, s_read_valid}, {30'd0, own});
                chk("s_read_data", {16'd0, s_read_data}, {16'd0, m_read_data});
            end
            if (hs) n++;
            cyc();
        end
        chk("beat_count", n, beats);
        chk("busy_clr", {31'd0, busy}, 32'd0);
        s_write_valid = '0;
        s_read_ready  = '0;
        m_read_valid  = 1'b0;
        m_write_ready = 1'b0;
    endtask

    initial begin
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_grant", {31'd0, grant_id}, 32'd0);
        chk("rst_s_req_ready", {30'd0, s_req_ready}, 32'd0);
        chk("rst_m_req_valid", {31'd0, m_req_valid}, 32'd0);
        chk("rst_m_write_valid", {31'd0, m_write_valid}, 32'd0);
        chk("rst_m_read_ready", {31'd0, m_read_ready}, 32'd0);

        // Single-beat write from req0.
        s_req_addr   = {32'h0000_0200, 32'h0000_0100};
        s_req_we     = 2'b01;
        s_req_burst  = 2'b00;
        s_req_beats  = {13'd0, 13'd1};
        s_write_data = {16'h5555, 16'hBEEF};
        s_req_valid  = 2'b01;
        serve(1'b0, 1, 1'b1, 2'b01, 2'b00, 1'b0, 32'h100);

        // Zero-length burst read from req1 moves one word.
        s_req_we    = 2'b00;
        s_req_burst = 2'b10;
        s_req_beats = {13'd0, 13'd0};
        m_read_data = 16'h1234;
        s_req_valid = 2'b10;
        serve(1'b1, 1, 1'b0, 2'b10, 2'b00, 1'b0, 32'h200);

        // Simultaneous 4-beat reads: req0 then req1.
        s_req_burst = 2'b11;
        s_req_beats = {13'd4, 13'd4};
        m_read_data = 16'hCAFE;
        s_req_valid = 2'b11;
        serve(1'b0, 4, 1'b0, 2'b01, 2'b00, 1'b0, 32'h100);
        serve(1'b1, 4, 1'b0, 2'b10, 2'b00, 1'b0, 32'h200);

        s_req_burst = 2'b00;
`ifdef OSD_MAM_ARB_FIXED_PRIO_EN
        s_req_valid = 2'b11;
        serve(1'b0, 1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h100);
        serve(1'b0, 1, 1'b0, 2'b00, 2'b00, 1'b0, 32'h100);
        serve(1'b0, 1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h100);
`else
        // req1 holds its request; req0 joins after each req1 grant: order 1,0,1,0.
        s_req_valid = 2'b10;
        serve(1'b1, 1, 1'b0, 2'b00, 2'b01, 1'b0, 32'h200);
        serve(1'b0, 1, 1'b0, 2'b01, 2'b00, 1'b0, 32'h100);
        serve(1'b1, 1, 1'b0, 2'b00, 2'b01, 1'b0, 32'h200);
        serve(1'b0, 1, 1'b0, 2'b11, 2'b00, 1'b0, 32'h100);
`endif

        // 3-beat write burst from req1 with a 5-cycle downstream stall; req0 drives junk.
        s_req_we      = 2'b10;
        s_req_burst   = 2'b10;
        s_req_beats   = {13'd3, 13'd7};
        s_write_data  = {16'h5555, 16'hAAAA};
        s_write_valid = 2'b01;
        s_req_valid   = 2'b10;
        serve(1'b1, 3, 1'b1, 2'b10, 2'b00, 1'b1, 32'h200);

        // Reset in the middle of a read burst.
        s_req_we    = 2'b00;
        s_req_beats = {13'd4, 13'd0};
        s_req_valid = 2'b10;
        for (int i = 0; i < 10 && !busy; i++) cyc();
        chk("r6_grant", {31'd0, grant_id}, 32'd1);
        m_req_ready = 1'b1;
        cyc();
        m_req_ready  = 1'b0;
        s_req_valid  = 2'b00;
        m_read_valid = 1'b1;
        s_read_ready = 2'b10;
        #1;
        chk("r6_read_valid_pre", {30'd0, s_read_valid}, 32'd2);
        #1;
        rst = 1'b1;
        #1;
        chk("r6_read_valid", {30'd0, s_read_valid}, 32'd0);
        chk("r6_m_read_ready", {31'd0, m_read_ready}, 32'd0);
        chk("r6_busy", {31'd0, busy}, 32'd0);
        chk("r6_grant_rst", {31'd0, grant_id}, 32'd0);
        chk("r6_s_req_ready", {30'd0, s_req_ready}, 32'd0);
        m_read_valid = 1'b0;
        s_read_ready = 2'b00;
        cyc();
        rst = 1'b0;
        cyc();
        chk("r6_idle_after", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
